card_shoe: RTL and testbench
============================

# card_shoe

Sequential card source for the Baccarat datapath: the producing end of the 4-bit card code that the hand-scoring logic consumes. On each accepted deal request it returns one card (1 = Ace … 10, 11 = J, 12 = Q, 13 = K) drawn without replacement from a shoe of `DECKS` standard decks. It keeps a remaining-count per rank and reports cards left and an empty condition. It replaces the free-running "grab the counter value" dealer, so no rank ever appears more than 4·`DECKS` times per shoe.

## Interface
- `DECKS`, default 1: number of 52-card decks in the shoe. Legal range is 1..8.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `deal_req`  in  1: request one card. Sampled on each rising edge.
- `reshuffle`  in  1: refill the shoe. Sampled on each rising edge.
- `busy`  out  1: high while a request is being serviced.
- `card_valid`  out  1: one-cycle pulse when `card` is updated.
- `card`  out  4: last dealt card code (1..13). Holds its value between deals.
- `cards_left`  out  9: cards remaining in the shoe (0..416).
- `shoe_empty`  out  1: high when `cards_left` == 0.

## Operation
- **Rank counter:** free-running, increments every cycle 1→2→…→13→1. Only `reset` stops or reloads it. It is the randomness source, sampled at request acceptance.
- **Per-rank counters:** 13 counters, each loaded with 4·`DECKS` at reset or reshuffle. Width is 6 bits.
- **FSM states:** IDLE, SEARCH.
- **IDLE, reshuffle:** `reshuffle`=1 reloads all rank counts and sets `cards_left`=52·`DECKS`. State stays IDLE. Reshuffle has priority over `deal_req` in the same cycle.
- **IDLE, deal accepted:** if `deal_req`=1, `reshuffle`=0 and `shoe_empty`=0, then `cand` ← rank counter value, `busy` ← 1, state → SEARCH.
- **IDLE, empty shoe:** `deal_req` with `shoe_empty`=1 is ignored. There is no error flag.
- **SEARCH, hit:** if count[`cand`] > 0, then in one edge: decrement count[`cand`], decrement `cards_left`, `card` ← `cand`, `card_valid` ← 1, `busy` ← 0, state → IDLE.
- **SEARCH, miss:** if count[`cand`] == 0, `cand` advances (13 wraps to 1) and state stays SEARCH.
- **Search bound:** entering SEARCH guarantees at least one nonzero rank, so there are at most 12 misses.
- **While busy:** `deal_req` and `reshuffle` are ignored. A request is not queued.
- **Arithmetic:** `cards_left` never underflows, since decrement happens only on a hit. Rank counts never go below 0.

## Timing
- **Reset values:** `busy`=0, `card_valid`=0, `card`=0, `cards_left`=52·`DECKS`, `shoe_empty`=0, rank counter=1, all rank counts=4·`DECKS`, state IDLE.
- **Latency:** request accepted at edge E0 gives SEARCH after E0. With k misses, the hit occurs at edge E(1+k), and `card_valid`/`card` are visible in the following cycle.
- **Throughput:** minimum 2 cycles per card. With `deal_req` held high, acceptances occur on every second edge.
- **Pulse width:** `card_valid` is exactly one cycle per dealt card, even if `deal_req` stays high.
- **Empty flag:** `shoe_empty` is derived from registered `cards_left`. It rises in the same cycle `card_valid` is high for the final card.
- **Reset mid-SEARCH:** abandons the search. No card is output and all state is at reset values.
- **Reshuffle during SEARCH:** ignored; the in-flight deal completes normally.

## Structure
- **Shared package `baccarat_pkg`:**
  - rank constants `CARD_ACE`=1 and `CARD_KING`=13;
  - `NUM_RANKS`=13 and `CARDS_PER_DECK`=52;
  - the 4-bit `card_t` typedef;
  - the `shoe_state_t` enum (IDLE, SEARCH).
- **Sub-module `rank_counter`:** wrap-around 1..13 counter with a synchronous reset to 1. It serves both as the free-running source and as the `cand` increment helper, via a combinational next-rank function in the package.
- Rank counts are stored as a 13-entry register array.

## Test plan
- **Reset:** `reset` for 2 cycles → `cards_left`=52, `card`=0, `busy`=0, `shoe_empty`=0. Rank counter reads 1 on the first cycle after reset.
- **Held request:** `deal_req` held high from the first edge after reset → cards 1,3,5,7,9,11,13,2,… with `card_valid` every 2nd cycle. `cards_left` decrements 52,51,50,….
- **Exhausted rank:** deal until rank 5 has been drawn 4 times, then force a request accepted with the rank counter at 5 → `card`=6 after one extra SEARCH cycle (3-cycle latency).
- **Drain and empty:** deal 52 cards → `shoe_empty`=1 in the cycle of the last `card_valid`. A further `deal_req` produces no `card_valid` and `busy` stays 0. Each rank appears exactly 4 times.
- **Reshuffle priority:** `reshuffle` and `deal_req` together in IDLE with `cards_left`=10 → `cards_left`=52 next cycle and no deal. `reshuffle` during SEARCH → ignored, and the deal completes with `cards_left` decremented.
- **Reset mid-search:** `reset` asserted in the cycle after acceptance → no `card_valid`, and all outputs at reset values.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the Baccarat datapath: card codes, deck
// geometry and the card-shoe FSM states.
package baccarat_pkg;

  localparam int NUM_RANKS      = 13;
  localparam int CARDS_PER_DECK = 52;

  typedef logic [3:0] card_t;

  localparam card_t CARD_ACE  = 4'd1;
  localparam card_t CARD_KING = 4'd13;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } shoe_state_t;

  // Rank successor on the 1..13 ring; anything out of range folds back to Ace.
  function automatic card_t next_rank(card_t r);
    if (r >= CARD_KING || r < CARD_ACE) return CARD_ACE;
    return card_t'(r + 4'd1);
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Request/response bundle between a dealer client (master) and the card shoe (slave).
interface card_shoe_if;
  import baccarat_pkg::*;

  // deal_req/reshuffle are sampled only while busy is low; a request seen
  // while busy is dropped, not queued. card_valid pulses for exactly one
  // cycle per dealt card, and card holds its value until the next deal.
  logic        deal_req;
  logic        reshuffle;
  logic        busy;
  logic        card_valid;
  card_t       card;
  logic [8:0]  cards_left;
  logic        shoe_empty;
  shoe_state_t state;

  modport master (
    output deal_req, reshuffle,
    input  busy, card_valid, card, cards_left, shoe_empty, state
  );

  modport slave (
    input  deal_req, reshuffle,
    output busy, card_valid, card, cards_left, shoe_empty, state
  );

endinterface

// File: rtl/card_shoe_rank_counter.sv
// Free-running 1..13 rank counter used as the shoe's randomness source.
module rank_counter
  import baccarat_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  output card_t rank
);

  always_ff @(posedge clock) begin
    if (reset) rank <= CARD_ACE;
    else       rank <= next_rank(rank);
  end

endmodule

// File: rtl/card_shoe.sv
// Card shoe: deals one card per accepted request, without replacement, from
// DECKS standard decks, using the free-running rank counter as the draw seed.
module card_shoe
  import baccarat_pkg::*;
#(
  parameter int DECKS = 1
) (
  input  logic        clock,
  input  logic        reset,
  card_shoe_if.slave  bus
);

  localparam logic [8:0] TOTAL_CARDS = 9'(CARDS_PER_DECK * DECKS);
  localparam logic [5:0] PER_RANK    = 6'(4 * DECKS);

  shoe_state_t state;
  card_t       rank;
  card_t       cand;
  card_t       card;
  logic        busy;
  logic        card_valid;
  logic [8:0]  cards_left;
  logic        shoe_empty;
  logic [5:0]  counts [1:NUM_RANKS];

  rank_counter u_rank_counter (
    .clock (clock),
    .reset (reset),
    .rank  (rank)
  );

  assign shoe_empty = (cards_left == 9'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= CARD_ACE;
      busy       <= 1'b0;
      card_valid <= 1'b0;
      card       <= '0;
      cards_left <= TOTAL_CARDS;
      for (int i = 1; i <= NUM_RANKS; i++) counts[i] <= PER_RANK;
    end else begin
      card_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Reshuffle wins over a simultaneous deal request.
          if (bus.reshuffle) begin
            cards_left <= TOTAL_CARDS;
            for (int i = 1; i <= NUM_RANKS; i++) counts[i] <= PER_RANK;
          end else if (bus.deal_req && !shoe_empty) begin
            cand  <= rank;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          // A nonempty shoe guarantees a hit within 12 misses.
          if (counts[cand] != 6'd0) begin
            counts[cand] <= counts[cand] - 6'd1;
            cards_left   <= cards_left - 9'd1;
            card         <= cand;
            card_valid   <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            cand <= next_rank(cand);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.card_valid = card_valid;
  assign bus.card       = card;
  assign bus.cards_left = cards_left;
  assign bus.shoe_empty = shoe_empty;
  assign bus.state      = state;

endmodule

// File: tb/tb_card_shoe.sv
// Randomized scoreboard bench for card_shoe against a draw-without-replacement model.
module tb_card_shoe;
  import baccarat_pkg::*;

  localparam int DECKS = 1;
  localparam int TOTAL = CARDS_PER_DECK * DECKS;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  card_shoe_if bus ();

  card_shoe #(.DECKS(DECKS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(string name, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The seed at any cycle is (cycles since reset release) mod 13 + 1; a draw
  // takes the first rank at or after the seed that still has cards, and each
  // skipped rank costs one extra cycle.
  int cyc     = 0;
  int tcnt    = 0;
  int free_at = 0;
  int m_left  = TOTAL;
  int m_rst   = 1;
  int m_count [1:13];
  int m_r;
  int m_k;

  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  int         exp_left_q[$];

  always @(posedge clock) begin
    m_rst = int'(reset);
    if (reset) begin
      tcnt    = 0;
      free_at = 0;
      m_left  = TOTAL;
      for (int r = 1; r <= 13; r++) m_count[r] = 4 * DECKS;
      exp_q.delete();
      exp_cyc_q.delete();
      exp_left_q.delete();
    end else begin
      if (cyc >= free_at) begin
        if (bus.reshuffle) begin
          m_left = TOTAL;
          for (int r = 1; r <= 13; r++) m_count[r] = 4 * DECKS;
        end else if (bus.deal_req && m_left > 0) begin
          m_r = (tcnt % 13) + 1;
          m_k = 0;
          while (m_count[m_r] == 0) begin
            m_r = (m_r % 13) + 1;
            m_k++;
          end
          m_count[m_r]--;
          m_left--;
          exp_q.push_back(4'(m_r));
          exp_cyc_q.push_back(cyc + 2 + m_k);
          exp_left_q.push_back(m_left);
          free_at = cyc + 2 + m_k;
        end
      end
      tcnt++;
    end
    cyc++;
  end

  // ---------------- monitor / scoreboard ----------------
  int         hist [1:13];
  int         dealt_q[$];
  logic [3:0] mon_card;
  int         mon_cyc;
  int         mon_left;

  always @(negedge clock) begin
    if (m_rst == 0) begin
      check("busy", int'(bus.busy), int'(cyc < free_at));
      if (bus.card_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_card_valid", 1, 0);
        end else begin
          mon_card = exp_q.pop_front();
          mon_cyc  = exp_cyc_q.pop_front();
          mon_left = exp_left_q.pop_front();
          check("card", int'(bus.card), int'(mon_card));
          check("valid_cycle", cyc, mon_cyc);
          check("cards_left", int'(bus.cards_left), mon_left);
          check("shoe_empty", int'(bus.shoe_empty), int'(mon_left == 0));
          if (bus.card >= 4'd1 && bus.card <= 4'd13) hist[bus.card]++;
          dealt_q.push_back(int'(bus.card));
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check("missing_card_valid", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        void'(exp_left_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(int n);
    @(negedge clock);
    reset         = 1'b1;
    bus.deal_req  = 1'b0;
    bus.reshuffle = 1'b0;
    for (int r = 1; r <= 13; r++) hist[r] = 0;
    dealt_q.delete();
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle(int extra);
    int n;
    n = 0;
    while (cyc < free_at && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, 1);
    repeat (extra) @(negedge clock);
  endtask

  int seq [8] = '{1, 3, 5, 7, 9, 11, 13, 2};

  initial begin
    int n;
    bus.deal_req  = 1'b0;
    bus.reshuffle = 1'b0;

    // Reset values
    do_reset(2);
    check("rst_cards_left", int'(bus.cards_left), TOTAL);
    check("rst_card", int'(bus.card), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_card_valid", int'(bus.card_valid), 0);
    check("rst_shoe_empty", int'(bus.shoe_empty), 0);
    check("rst_state", int'(bus.state), int'(IDLE));

    // Held request straight out of reset: seeds on every other rank
    bus.deal_req = 1'b1;
    repeat (40) @(negedge clock);
    bus.deal_req = 1'b0;
    wait_idle(2);
    check("held_count", dealt_q.size(), 20);
    for (int i = 0; i < 8; i++)
      if (dealt_q.size() > i) check("held_seq", dealt_q[i], seq[i]);

    // Drain with random requests, then poke the empty shoe
    do_reset(2);
    n = 0;
    while (!(m_left == 0 && cyc >= free_at) && n < 3000) begin
      bus.deal_req = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 0, 1);
    check("drain_empty", int'(bus.shoe_empty), 1);
    check("drain_left", int'(bus.cards_left), 0);
    bus.deal_req = 1'b1;
    repeat (10) @(negedge clock);
    bus.deal_req = 1'b0;
    check("empty_busy", int'(bus.busy), 0);
    for (int r = 1; r <= 13; r++) check("rank_hist", hist[r], 4 * DECKS);

    // Reshuffle priority in IDLE with 10 cards left
    do_reset(2);
    n = 0;
    while (m_left > 10 && n < 1000) begin
      bus.deal_req = (m_left > 10);
      @(negedge clock);
      n++;
    end
    bus.deal_req = 1'b0;
    if (n >= 1000) check("deal_to_10_timeout", 0, 1);
    wait_idle(1);
    check("left_before_reshuffle", int'(bus.cards_left), 10);
    bus.reshuffle = 1'b1;
    bus.deal_req  = 1'b1;
    @(negedge clock);
    bus.reshuffle = 1'b0;
    bus.deal_req  = 1'b0;
    check("reshuffle_left", int'(bus.cards_left), TOTAL);
    check("reshuffle_no_deal", int'(bus.busy), 0);

    // Reshuffle during SEARCH is ignored
    bus.deal_req = 1'b1;
    @(negedge clock);
    bus.deal_req  = 1'b0;
    bus.reshuffle = 1'b1;
    @(negedge clock);
    bus.reshuffle = 1'b0;
    wait_idle(1);
    check("search_reshuffle_left", int'(bus.cards_left), TOTAL - 1);

    // Reset in the cycle after acceptance abandons the deal
    bus.deal_req = 1'b1;
    @(negedge clock);
    bus.deal_req = 1'b0;
    check("accepted_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_valid", int'(bus.card_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_left", int'(bus.cards_left), TOTAL);
    check("midrst_card", int'(bus.card), 0);
    check("midrst_empty", int'(bus.shoe_empty), 0);
    repeat (5) @(negedge clock);

    // Random mix of requests and occasional reshuffles
    for (int i = 0; i < 800; i++) begin
      bus.deal_req  = ($urandom_range(0, 1) == 1);
      bus.reshuffle = ($urandom_range(0, 39) == 0);
      @(negedge clock);
    end
    bus.deal_req  = 1'b0;
    bus.reshuffle = 1'b0;
    wait_idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
